// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default datapath widths and the result-drain FSM state encoding.
package tpu_pkg;

    localparam int TPU_ADDRESSSIZE    = 10;
    localparam int TPU_PARTIAL_SUM_BW = 20;
    localparam int TPU_MATRIX_SIZE    = 8;

    typedef enum logic [2:0] {
        DRAIN_IDLE = 3'd0,
        DRAIN_RD   = 3'd1,
        DRAIN_CAP  = 3'd2,
        DRAIN_SEND = 3'd3,
        DRAIN_DONE = 3'd4
    } drain_state_e;

endpackage

// File: rtl/result_relu_lane.sv
// Single result lane clamp: negative two's-complement values become zero, others pass through.
module result_relu_lane #(
    parameter int LANE_W = 20
) (
    input  logic [LANE_W-1:0] lane_in,
    output logic [LANE_W-1:0] lane_out
);

    // Sign-bit driven clamp to zero
    always_comb begin
        if (lane_in[LANE_W-1]) begin
            lane_out = '0;
        end else begin
            lane_out = lane_in;
        end
    end

endmodule

// File: rtl/result_drain_ctrl.sv
// Drains NUM_ROWS result rows from the results SRAM onto a valid/ready stream.
// Optional macro RESULT_DRAIN_RELU_EN clamps negative lanes to zero at capture.
module result_drain_ctrl
    import tpu_pkg::*;
#(
    parameter int ADDRESSSIZE    = TPU_ADDRESSSIZE,
    parameter int PARTIAL_SUM_BW = TPU_PARTIAL_SUM_BW,
    parameter int MATRIX_SIZE    = TPU_MATRIX_SIZE,
    parameter int NUM_ROWS       = 8
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    output logic                                  sram_rd_req,
    output logic [ADDRESSSIZE-1:0]                sram_address,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_data_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] out_data,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done
);

    localparam int DATA_W = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    drain_state_e            state_r;
    drain_state_e            state_nxt_s;
    logic [ROW_W-1:0]        row_r;
    logic [ROW_W-1:0]        row_nxt_s;
    logic [ADDRESSSIZE-1:0]  base_r;
    logic [ADDRESSSIZE-1:0]  base_nxt_s;

    logic                    rd_req_nxt_s;
    logic [ADDRESSSIZE-1:0]  addr_nxt_s;
    logic                    valid_nxt_s;
    logic                    last_nxt_s;
    logic                    busy_nxt_s;
    logic                    done_nxt_s;

    logic                    rd_req_r;
    logic [ADDRESSSIZE-1:0]  addr_r;
    logic                    valid_r;
    logic                    last_r;
    logic                    busy_r;
    logic                    done_r;
    logic [DATA_W-1:0]       data_r;
    logic [DATA_W-1:0]       cap_data_s;

`ifdef RESULT_DRAIN_RELU_EN
    for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_relu
        result_relu_lane #(
            .LANE_W(PARTIAL_SUM_BW)
        ) u_relu_lane (
            .lane_in (sram_data_in[g*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
            .lane_out(cap_data_s[g*PARTIAL_SUM_BW +: PARTIAL_SUM_BW])
        );
    end
`else
    assign cap_data_s = sram_data_in;
`endif

    // State, row counter and latched base address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= DRAIN_IDLE;
            row_r   <= '0;
            base_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            row_r   <= row_nxt_s;
            base_r  <= base_nxt_s;
        end
    end

    // Next-state, row and base selection
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        base_nxt_s  = base_r;
        case (state_r)
            DRAIN_IDLE: begin
                if (start) begin
                    state_nxt_s = DRAIN_RD;
                    row_nxt_s   = '0;
                    base_nxt_s  = base_addr;
                end else begin
                    state_nxt_s = DRAIN_IDLE;
                end
            end
            DRAIN_RD:   state_nxt_s = DRAIN_CAP;
            DRAIN_CAP:  state_nxt_s = DRAIN_SEND;
            DRAIN_SEND: begin
                // out_valid is high exactly while in SEND, so ready alone completes the beat
                if (out_ready) begin
                    if (row_r == LAST_ROW) begin
                        state_nxt_s = DRAIN_DONE;
                    end else begin
                        state_nxt_s = DRAIN_RD;
                        row_nxt_s   = row_r + ROW_W'(1);
                    end
                end else begin
                    state_nxt_s = DRAIN_SEND;
                end
            end
            DRAIN_DONE: state_nxt_s = DRAIN_IDLE;
            default:    state_nxt_s = DRAIN_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so every output leaves a flop
    always_comb begin
        rd_req_nxt_s = 1'b0;
        addr_nxt_s   = '0;
        valid_nxt_s  = 1'b0;
        last_nxt_s   = 1'b0;
        done_nxt_s   = 1'b0;
        busy_nxt_s   = (state_nxt_s != DRAIN_IDLE);
        case (state_nxt_s)
            DRAIN_RD, DRAIN_CAP: begin
                rd_req_nxt_s = 1'b1;
                addr_nxt_s   = base_nxt_s + ADDRESSSIZE'(row_nxt_s);
            end
            DRAIN_SEND: begin
                valid_nxt_s = 1'b1;
                last_nxt_s  = (row_nxt_s == LAST_ROW);
            end
            DRAIN_DONE: done_nxt_s = 1'b1;
            DRAIN_IDLE: done_nxt_s = 1'b0;
            default:    done_nxt_s = 1'b0;
        endcase
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_req_r <= 1'b0;
            addr_r   <= '0;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            rd_req_r <= rd_req_nxt_s;
            addr_r   <= addr_nxt_s;
            valid_r  <= valid_nxt_s;
            last_r   <= last_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    // Row capture at the end of CAP; held untouched through the SEND stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_r <= '0;
        end else if (state_r == DRAIN_CAP) begin
            data_r <= cap_data_s;
        end else begin
            data_r <= data_r;
        end
    end

    assign sram_rd_req  = rd_req_r;
    assign sram_address = addr_r;
    assign out_valid    = valid_r;
    assign out_last     = last_r;
    assign out_data     = data_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Randomized self-checking bench for result_drain_ctrl with a cycle-level behavioural reference.
module tb_result_drain_ctrl;

    localparam int AW    = 10;
    localparam int W     = 20;
    localparam int L     = 8;
    localparam int NR    = 8;
    localparam int DW    = W * L;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          sram_rd_req, out_valid, out_last, busy, done;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_data_in, out_data;

    logic [DW-1:0] mem [DEPTH];
    int chk = 0;
    int err = 0;

    // reference model state: row cadence is RD, CAP, then SEND until accepted
    bit m_active = 1'b0, m_done = 1'b0;
    int m_row = 0, m_base = 0, m_t = 0;

    logic [DW-1:0] obs_data [$];
    bit            obs_last [$];
    int            obs_addr [$];
    int  done_cnt = 0, busy_cyc = 0;
    bit  prev_valid = 1'b0, prev_last = 1'b0, prev_rd = 1'b0;
    logic [DW-1:0] prev_data = '0;

    result_drain_ctrl #(
        .ADDRESSSIZE(AW), .PARTIAL_SUM_BW(W), .MATRIX_SIZE(L), .NUM_ROWS(NR)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .sram_rd_req(sram_rd_req), .sram_address(sram_address), .sram_data_in(sram_data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // results SRAM with one cycle read latency
    always @(posedge clk) begin
        if (sram_rd_req) sram_data_in <= mem[sram_address];
    end

    function automatic logic [DW-1:0] relu_row(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
`ifdef RESULT_DRAIN_RELU_EN
        for (int i = 0; i < L; i++) begin
            if (v[i*W + W - 1]) r[i*W +: W] = '0;
        end
`endif
        return r;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // advance the reference by the edge just passed, compare, and record observations
    always @(negedge clk) begin
        logic          e_rd, e_valid, e_busy;
        logic [AW-1:0] e_addr;
        if (!rstn) begin
            m_active = 1'b0; m_done = 1'b0; m_row = 0; m_base = 0; m_t = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_row = 0; m_base = int'(base_addr); m_t = 0;
            end
        end else if (m_t >= 2 && out_ready) begin
            if (m_row == NR - 1) begin
                m_active = 1'b0; m_done = 1'b1;
            end else begin
                m_row++; m_t = 0;
            end
        end else begin
            m_t++;
        end
        e_rd    = m_active && (m_t < 2);
        e_valid = m_active && (m_t >= 2);
        e_busy  = m_active || m_done;
        e_addr  = AW'(m_base + m_row);
        check1("busy", busy, e_busy);
        check1("done", done, m_done);
        check1("sram_rd_req", sram_rd_req, e_rd);
        check1("out_valid", out_valid, e_valid);
        check1("out_last", out_last, e_valid && (m_row == NR - 1));
        if (e_rd || !e_busy)
            checkv("sram_address", DW'(sram_address), DW'(e_rd ? e_addr : AW'(0)));
        if (e_valid)
            checkv("out_data", out_data, relu_row(mem[e_addr]));
        else if (!rstn)
            checkv("out_data_rst", out_data, '0);
        if (rstn && prev_valid && out_ready) begin
            obs_data.push_back(prev_data);
            obs_last.push_back(prev_last);
        end
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (sram_rd_req && !prev_rd) obs_addr.push_back(int'(sram_address));
        prev_valid = out_valid; prev_data = out_data; prev_last = out_last; prev_rd = sram_rd_req;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_zero_checks(input string tag);
        check1({tag, "_valid"}, out_valid, 1'b0);
        check1({tag, "_last"}, out_last, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_rd_req"}, sram_rd_req, 1'b0);
        checkv({tag, "_addr"}, DW'(sram_address), '0);
        checkv({tag, "_data"}, out_data, '0);
    endtask

    // mode 0: ready high; 1: random ready and stray starts; 2: stall row 2;
    // 3: extra start in SEND of row 4; 4: reset in CAP of row 3
    task automatic run_drain(input int base, input int mode);
        int d0;
        int stall;
        bit pulsed, pr, finished;
        d0 = done_cnt; stall = 5; pulsed = 1'b0; pr = 1'b0; finished = 1'b0;
        obs_data.delete(); obs_last.delete(); obs_addr.delete();
        busy_cyc = 0;
        base_addr = AW'(base);
        start = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 600; c++) begin
            tick();
            start = 1'b0;
            base_addr = AW'($urandom);
            if (done_cnt != d0) begin
                finished = 1'b1;
                break;
            end
            out_ready = 1'b1;
            case (mode)
                1: begin
                    out_ready = 1'($urandom % 2);
                    start = ($urandom % 6 == 0);
                end
                2: if (obs_data.size() == 2 && out_valid && stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end
                3: if (obs_data.size() == 4 && out_valid && !pulsed) begin
                    start = 1'b1;
                    pulsed = 1'b1;
                end
                4: if (obs_data.size() == 3 && sram_rd_req && pr) begin
                    rstn = 1'b0;
                    #1;
                    reset_zero_checks("rst_in_cap");
                    repeat (2) tick();
                    rstn = 1'b1;
                    finished = 1'b1;
                    break;
                end
                default: out_ready = 1'b1;
            endcase
            pr = sram_rd_req;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check1("drain_completes_in_budget", finished, 1'b1);
        repeat (2) tick();
    endtask

    initial begin
        int exp_addr [8];
        int d0;
        logic [DW-1:0] v;
        logic [W-1:0]  lane;
        exp_addr = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
        for (int a = 0; a < DEPTH; a++)
            mem[a] = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < NR; k++) mem[k] = {L{W'(k)}};
        v = '0;
        v[W-1:0]   = 20'hFFFFB;
        v[2*W-1:W] = 20'd7;
        mem[100] = v;

        #1 rstn = 1'b0;
        repeat (3) tick();
        reset_zero_checks("reset");
        rstn = 1'b1;
        tick();

        // rows k hold {8{k}}; one row per three cycles, busy for 25 cycles
        d0 = done_cnt;
        run_drain(0, 0);
        check1("t1_beat_count", obs_data.size() == NR, 1'b1);
        for (int k = 0; k < NR; k++)
            checkv("t1_beat", (k < obs_data.size()) ? obs_data[k] : '1, {L{W'(k)}});
        check1("t1_last_on_beat7", (obs_last.size() == NR) ? obs_last[NR-1] : 1'b0, 1'b1);
        check1("t1_no_last_beat6", (obs_last.size() == NR) ? obs_last[NR-2] : 1'b1, 1'b0);
        checkv("t1_busy_cycles", DW'(busy_cyc), DW'(25));
        checkv("t1_done_pulses", DW'(done_cnt - d0), DW'(1));

        run_drain(5, 2);
        check1("t2_beat_count", obs_data.size() == NR, 1'b1);

        run_drain(1020, 0);
        for (int i = 0; i < NR; i++)
            checkv("t3_addr", DW'((i < obs_addr.size()) ? obs_addr[i] : -1), DW'(exp_addr[i]));

        d0 = done_cnt;
        run_drain(40, 3);
        repeat (30) tick();
        check1("t4_beat_count", obs_data.size() == NR, 1'b1);
        checkv("t4_done_pulses", DW'(done_cnt - d0), DW'(1));

        run_drain(200, 4);
        run_drain(200, 0);
        check1("t5_beat_count", obs_data.size() == NR, 1'b1);
        checkv("t5_first_addr", DW'((obs_addr.size() > 0) ? obs_addr[0] : -1), DW'(200));
        for (int k = 0; k < NR; k++)
            checkv("t5_beat", (k < obs_data.size()) ? obs_data[k] : 'x, relu_row(mem[200 + k]));

        run_drain(100, 0);
        v = (obs_data.size() > 0) ? obs_data[0] : '1;
        lane = v[W-1:0];
`ifdef RESULT_DRAIN_RELU_EN
        checkv("t6_neg_lane", DW'(lane), DW'(20'h00000));
`else
        checkv("t6_neg_lane", DW'(lane), DW'(20'hFFFFB));
`endif
        lane = v[2*W-1:W];
        checkv("t6_pos_lane", DW'(lane), DW'(20'd7));

        for (int r = 0; r < 6; r++) begin
            d0 = done_cnt;
            run_drain(int'($urandom_range(0, DEPTH - 1)), 1);
            check1("t7_beat_count", obs_data.size() == NR, 1'b1);
            checkv("t7_done_pulses", DW'(done_cnt - d0), DW'(1));
        end

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_drain_ctrl.md
RESULT_DRAIN_CTRL -- requirements
Module: result_drain_ctrl

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10, meaning the results-SRAM address width.
REQ-002 SHALL have parameter PARTIAL_SUM_BW, default 20, meaning the bits per result lane.
REQ-003 SHALL have parameter MATRIX_SIZE, default 8, meaning the number of lanes per row.
REQ-004 SHALL have parameter NUM_ROWS, default 8, meaning the number of rows drained per start.
REQ-005 SHALL have ports clk  in  1  clock; rstn  in  1  reset: one clock, asynchronous active-low.
REQ-006 SHALL have port start  in  1  single-cycle drain request.
REQ-007 SHALL have port base_addr  in  ADDRESSSIZE  first row address, latched when start is accepted.
REQ-008 SHALL have port sram_rd_req  out  1  high while this block owns the results-SRAM address.
REQ-009 SHALL have port sram_address  out  ADDRESSSIZE  results-SRAM read address.
REQ-010 SHALL have port sram_data_in  in  PARTIAL_SUM_BW*MATRIX_SIZE  results-SRAM read data; 1-cycle synchronous read latency.
REQ-011 SHALL have ports out_valid  out  1; out_ready  in  1; out_data  out  PARTIAL_SUM_BW*MATRIX_SIZE; out_last  out  1.
REQ-012 SHALL have ports busy  out  1  drain in progress; done  out  1  one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, RD, CAP, SEND, DONE.
REQ-014 IDLE->RD SHALL occur on start=1; base_addr latched, row counter cleared; start in any other state ignored.
REQ-015 RD SHALL drive sram_rd_req=1, sram_address=base+row, and go to CAP next cycle.
REQ-016 CAP SHALL keep sram_rd_req=1 with the address held, register sram_data_in into out_data at the cycle end, and go to SEND.
REQ-017 SEND SHALL hold out_valid=1 and out_data stable until out_valid&out_ready; out_data SHALL NOT change while out_valid=1 without ready.
REQ-018 On the SEND handshake: if row==NUM_ROWS-1, go to DONE; else row+1 and go to RD.
REQ-019 out_last SHALL equal out_valid AND (row==NUM_ROWS-1).
REQ-020 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-021 busy SHALL be 1 in RD, CAP, SEND, DONE and 0 in IDLE.
REQ-022 sram_address SHALL compute (base_addr+row) mod 2^ADDRESSSIZE, wrapping silently past the maximum address.
REQ-023 Minimum throughput with out_ready held at 1: one row per 3 cycles; latency start->first out_valid = 3 cycles.
REQ-024 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-025 sram_rd_req=0 outside RD/CAP; sram_address SHALL be 0 in IDLE.

Reset
REQ-026 rstn=0 SHALL, asynchronously and from any state, force IDLE, row=0, and latched base=0, with outputs out_valid, out_last, busy, done, sram_rd_req, sram_address, out_data = 0.
REQ-027 A reset during SEND SHALL drop the pending row with no retransmission; the next start begins again at row 0.

Configuration
REQ-028 With macro RESULT_DRAIN_RELU_EN defined, each PARTIAL_SUM_BW-bit signed lane SHALL be clamped to 0 if negative at CAP capture; non-negative lanes pass unchanged.
REQ-029 Without RESULT_DRAIN_RELU_EN, lanes SHALL pass bit-exact, with no added logic or latency in either build.

Structure
REQ-030 Shared package tpu_pkg SHALL hold the ADDRESSSIZE, PARTIAL_SUM_BW, and MATRIX_SIZE defaults and the drain-state enumeration.
REQ-031 The per-lane clamp SHALL be sub-module result_relu_lane, instantiated MATRIX_SIZE times under RESULT_DRAIN_RELU_EN only.

Verification
REQ-032 Test: base_addr=0, start, out_ready=1, SRAM row k = {8{k}} -> 8 beats of out_data {8{k}} for k=0..7; out_last on beat 7; done 1 cycle after; busy high for 25 cycles.
REQ-033 Test: out_ready=0 for 5 cycles on row 2 -> out_valid held, out_data unchanged, sram_rd_req=0 throughout the stall.
REQ-034 Test: base_addr=1020 -> addresses issued 1020, 1021, 1022, 1023, 0, 1, 2, 3.
REQ-035 Test: start pulsed again during SEND of row 4 -> ignored; exactly 8 beats total and one done pulse.
REQ-036 Test: rstn low during CAP of row 3 -> all outputs 0 immediately; a new start yields rows 0..7 correctly.
REQ-037 Test: with RESULT_DRAIN_RELU_EN, lane value -5 (0xFFFFB) -> 0x00000 and lane +7 -> 7; without the macro, 0xFFFFB passes unchanged.
